// File: rtl/snake_pkg.sv
// Shared snake-game constants: grid geometry, playfield bounds, coordinate widths
// and the food placer state encoding.
package snake_pkg;

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned GRID    = 10;
    localparam int unsigned SCR_W   = 640;
    localparam int unsigned SCR_H   = 480;
    localparam int unsigned X_MIN   = 10;
    localparam int unsigned X_MAX   = 620;
    localparam int unsigned Y_MIN   = 10;
    localparam int unsigned Y_MAX   = 460;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned ADDR_W  = $clog2(MAX_LEN);
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned INIT_X  = 320;
    localparam int unsigned INIT_Y  = 240;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SCAN   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_COMMIT = 3'd4
    } placer_state_e;

endpackage

// File: rtl/food_cell_check.sv
// Combinational screen of one candidate food cell: grid alignment, playfield
// range and difference from the currently displayed food.
module food_cell_check
    import snake_pkg::*;
#(
    parameter int unsigned GRID_P  = GRID,
    parameter int unsigned X_MIN_P = X_MIN,
    parameter int unsigned X_MAX_P = X_MAX,
    parameter int unsigned Y_MIN_P = Y_MIN,
    parameter int unsigned Y_MAX_P = Y_MAX
) (
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    input  logic [X_W-1:0] old_x_i,
    input  logic [Y_W-1:0] old_y_i,
    output logic           pass_o
);

    logic [31:0] x_ext_s;
    logic [31:0] y_ext_s;
    logic        aligned_s;
    logic        in_range_s;
    logic        not_old_s;

    assign x_ext_s    = 32'(x_i);
    assign y_ext_s    = 32'(y_i);
    assign aligned_s  = ((x_ext_s % GRID_P) == 32'd0) && ((y_ext_s % GRID_P) == 32'd0);
    assign in_range_s = (x_ext_s >= X_MIN_P) && (x_ext_s <= X_MAX_P) &&
                        (y_ext_s >= Y_MIN_P) && (y_ext_s <= Y_MAX_P);
    assign not_old_s  = (x_i != old_x_i) || (y_i != old_y_i);
    assign pass_o     = aligned_s && in_range_s && not_old_s;

endmodule

// File: rtl/food_placer.sv
// Picks a new food cell after the snake eats: samples the random candidate until
// one passes the cell check, scans the body RAM for overlap, then commits it.
module food_placer
    import snake_pkg::*;
#(
    parameter int unsigned GRID    = snake_pkg::GRID,
    parameter int unsigned X_MIN   = snake_pkg::X_MIN,
    parameter int unsigned X_MAX   = snake_pkg::X_MAX,
    parameter int unsigned Y_MIN   = snake_pkg::Y_MIN,
    parameter int unsigned Y_MAX   = snake_pkg::Y_MAX,
    parameter int unsigned MAX_LEN = snake_pkg::MAX_LEN,
    parameter int unsigned INIT_X  = snake_pkg::INIT_X,
    parameter int unsigned INIT_Y  = snake_pkg::INIT_Y
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [X_W-1:0]    candX,
    input  logic [Y_W-1:0]    candY,
    input  logic              eat,
    input  logic [LEN_W-1:0]  snake_len,
    output logic [ADDR_W-1:0] seg_addr,
    input  logic [X_W-1:0]    seg_x,
    input  logic [Y_W-1:0]    seg_y,
    output logic [X_W-1:0]    foodX,
    output logic [Y_W-1:0]    foodY,
    output logic              food_valid,
    output logic              busy,
    output logic              placed
);

    placer_state_e     state_q, state_d;
    logic [X_W-1:0]    cand_x_q, cand_x_d;
    logic [Y_W-1:0]    cand_y_q, cand_y_d;
    logic [ADDR_W-1:0] seg_addr_q, seg_addr_d;
    logic [X_W-1:0]    food_x_q, food_x_d;
    logic [Y_W-1:0]    food_y_q, food_y_d;
    logic              food_valid_q, food_valid_d;
    logic              busy_q, busy_d;
    logic              placed_q, placed_d;
    logic              cell_pass_s;
    logic              seg_hit_s;
    logic              last_addr_s;

    food_cell_check #(
        .GRID_P  (GRID),
        .X_MIN_P (X_MIN),
        .X_MAX_P (X_MAX),
        .Y_MIN_P (Y_MIN),
        .Y_MAX_P (Y_MAX)
    ) u_cell_check (
        .x_i     (candX),
        .y_i     (candY),
        .old_x_i (food_x_q),
        .old_y_i (food_y_q),
        .pass_o  (cell_pass_s)
    );

    assign seg_hit_s   = (seg_x == cand_x_q) && (seg_y == cand_y_q);
    assign last_addr_s = ({1'b0, seg_addr_q} == (snake_len - 7'd1));

    // Next-state, scan counter and commit decisions.
    always_comb begin
        state_d      = state_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        seg_addr_d   = seg_addr_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        placed_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eat) begin
                    state_d      = ST_SAMPLE;
                    food_valid_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                cand_x_d = candX;
                cand_y_d = candY;
                if (!cell_pass_s) begin
                    state_d = ST_SAMPLE;
                end else if (snake_len == 7'd0) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d    = ST_SCAN;
                    seg_addr_d = 6'd0;
                end
            end
            ST_SCAN: begin
                // RAM data lags the address by one cycle, so address 0 has no result yet.
                if ((seg_addr_q != 6'd0) && seg_hit_s) begin
                    state_d = ST_SAMPLE;
                end else if (last_addr_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    seg_addr_d = seg_addr_q + 6'd1;
                end
            end
            ST_DRAIN: begin
                if (seg_hit_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                food_x_d     = cand_x_q;
                food_y_d     = cand_y_q;
                food_valid_d = 1'b1;
                placed_d     = 1'b1;
                seg_addr_d   = 6'd0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cand_x_q     <= 10'd0;
            cand_y_q     <= 9'd0;
            seg_addr_q   <= 6'd0;
            food_x_q     <= X_W'(INIT_X);
            food_y_q     <= Y_W'(INIT_Y);
            food_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            placed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            seg_addr_q   <= seg_addr_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            placed_q     <= placed_d;
        end
    end

    assign seg_addr   = seg_addr_q;
    assign foodX      = food_x_q;
    assign foodY      = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign placed     = placed_q;

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: directed candidate sequences push expected
// placements; a monitor pops and compares whenever placed pulses.
module tb_food_placer;

    logic       CLOCK_50;
    logic       resetn;
    logic [9:0] candX;
    logic [8:0] candY;
    logic       eat;
    logic [6:0] snake_len;
    logic [5:0] seg_addr;
    logic [9:0] seg_x;
    logic [8:0] seg_y;
    logic [9:0] foodX;
    logic [8:0] foodY;
    logic       food_valid;
    logic       busy;
    logic       placed;

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_err    = 0;
    int         edge_n   = 0;
    int         eat_e;
    logic [9:0] body_x [64];
    logic [8:0] body_y [64];

    food_placer dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .candX      (candX),
        .candY      (candY),
        .eat        (eat),
        .snake_len  (snake_len),
        .seg_addr   (seg_addr),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .foodX      (foodX),
        .foodY      (foodY),
        .food_valid (food_valid),
        .busy       (busy),
        .placed     (placed)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) edge_n <= edge_n + 1;

    // Synchronous-read body RAM, one cycle latency.
    always @(posedge CLOCK_50) begin
        seg_x <= body_x[seg_addr];
        seg_y <= body_y[seg_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every placed pulse must match the oldest expected placement.
    always @(posedge CLOCK_50) begin
        #1;
        if (placed === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_placed: got foodX=%0d foodY=%0d expected no placement", foodX, foodY);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc >= 0) chk("placed_cycle", edge_n, mon_e.cyc);
                chk("foodX", int'(foodX), int'(mon_e.x));
                chk("foodY", int'(foodY), int'(mon_e.y));
                chk("food_valid_at_placed", int'(food_valid), 1);
            end
        end
    end

    task automatic start_eat(input int x, input int y);
        @(negedge CLOCK_50);
        eat   = 1'b1;
        candX = 10'(x);
        candY = 9'(y);
        eat_e = edge_n + 1;
    endtask

    initial begin
        resetn    = 1'b0;
        eat       = 1'b0;
        candX     = 10'd0;
        candY     = 9'd0;
        snake_len = 7'd3;
        for (int i = 0; i < 64; i++) begin
            body_x[i] = 10'(10 + 10 * (i % 60));
            body_y[i] = (i < 60) ? 9'd400 : 9'd410;
        end
        body_x[0] = 10'd100; body_y[0] = 9'd100;
        body_x[1] = 10'd110; body_y[1] = 9'd100;
        body_x[2] = 10'd120; body_y[2] = 9'd100;

        // Reset held two cycles.
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        chk("reset_foodX", int'(foodX), 320);
        chk("reset_foodY", int'(foodY), 240);
        chk("reset_food_valid", int'(food_valid), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_placed", int'(placed), 0);
        chk("reset_seg_addr", int'(seg_addr), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // Bad candidates: misaligned/out of range, misaligned, below X_MIN, old food, then good.
        start_eat(625, 150);
        sb.push_back('{cyc: eat_e + 10, x: 10'd200, y: 9'd150});
        @(negedge CLOCK_50);
        eat = 1'b0;
        chk("busy_after_eat", int'(busy), 1);
        chk("food_valid_cleared", int'(food_valid), 0);
        @(negedge CLOCK_50); candX = 10'd205; candY = 9'd150;
        @(negedge CLOCK_50); candX = 10'd0;   candY = 9'd150;
        @(negedge CLOCK_50); candX = 10'd320; candY = 9'd240;
        @(negedge CLOCK_50); candX = 10'd200; candY = 9'd150;
        @(negedge CLOCK_50); candX = 10'd7;   candY = 9'd3;
        repeat (7) @(negedge CLOCK_50);
        chk("bad_cand_drained", sb.size(), 0);
        chk("idle_busy", int'(busy), 0);

        // Body collision on segment 1, then a clear candidate.
        start_eat(110, 100);
        sb.push_back('{cyc: -1, x: 10'd300, y: 9'd300});
        @(negedge CLOCK_50);
        eat = 1'b0;
        @(negedge CLOCK_50); candX = 10'd300; candY = 9'd300;
        repeat (14) @(negedge CLOCK_50);
        chk("collision_drained", sb.size(), 0);

        // Clean placement, L=3: placed six cycles after the eat edge.
        start_eat(200, 150);
        sb.push_back('{cyc: eat_e + 6, x: 10'd200, y: 9'd150});
        @(negedge CLOCK_50);
        eat = 1'b0;
        @(negedge CLOCK_50); candX = 10'd90; candY = 9'd90;
        repeat (8) @(negedge CLOCK_50);
        chk("clean_drained", sb.size(), 0);

        // Full snake with a second eat mid-scan that must be ignored.
        snake_len = 7'd64;
        start_eat(500, 50);
        sb.push_back('{cyc: eat_e + 67, x: 10'd500, y: 9'd50});
        @(negedge CLOCK_50);
        eat = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLOCK_50);
            chk("seg_addr_sweep", int'(seg_addr), i);
            if (i == 10) begin
                eat = 1'b1;
            end else begin
                eat = 1'b0;
            end
        end
        repeat (12) @(negedge CLOCK_50);
        chk("full_drained", sb.size(), 0);
        chk("full_busy_done", int'(busy), 0);

        // Reset in the middle of a scan discards the placement.
        snake_len = 7'd3;
        start_eat(400, 200);
        @(negedge CLOCK_50);
        eat = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        @(posedge CLOCK_50);
        #1;
        chk("midscan_rst_foodX", int'(foodX), 320);
        chk("midscan_rst_foodY", int'(foodY), 240);
        chk("midscan_rst_food_valid", int'(food_valid), 1);
        chk("midscan_rst_busy", int'(busy), 0);
        chk("midscan_rst_placed", int'(placed), 0);
        chk("midscan_rst_seg_addr", int'(seg_addr), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        chk("post_reset_idle", int'(busy), 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
